pbs_move_input: RTL and testbench

//  Input-side counterpart of the battle display path: captures the player's move entry from raw board inputs.

---
 rtl/pbs_pkg.sv | 20 ++
 rtl/pbs_debounce.sv | 72 +++++++
 rtl/pbs_move_input.sv | 99 +++++++++
 tb/tb_pbs_move_input.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pbs_pkg.sv
// Shared constants for the player-move input path: move width, the four
// switch-selected move codes, and the move-offer state encoding.
package pbs_pkg;

  localparam int MOVE_W = 2;

  // Move codes as presented on SW[1:0]
  localparam logic [MOVE_W-1:0] MOVE_CODE_0 = 2'b00;
  localparam logic [MOVE_W-1:0] MOVE_CODE_1 = 2'b01;
  localparam logic [MOVE_W-1:0] MOVE_CODE_2 = 2'b10;
  localparam logic [MOVE_W-1:0] MOVE_CODE_3 = 2'b11;

  // Offer FSM: wait for a press, offer the move, then wait for key release
  typedef enum logic [1:0] {
    ST_IDLE     = 2'b00,
    ST_OFFER    = 2'b01,
    ST_WAIT_REL = 2'b10
  } pbs_state_e;

endpackage

// File: rtl/pbs_debounce.sv
// Two-flop synchroniser and counter debouncer for an active-low key.
// level_o is the debounced level (1 = pressed); press_o is a one-cycle
// strobe on the debounced released->pressed transition.
module pbs_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic key_n_i,
  output logic level_o,
  output logic press_o
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic             sync1_q;
  logic             sync2_q;
  logic             lvl_n_q;   // debounced level in key_n polarity (1 = released)
  logic             lvl_n_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             press_q;
  logic             press_d;

  // Bring the asynchronous key into the clock domain; idle level is released
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= key_n_i;
      sync2_q <= sync1_q;
    end
  end

  // Count consecutive cycles the synced key disagrees with the debounced level;
  // flip the level once the disagreement has lasted DEBOUNCE_CYCLES cycles
  always_comb begin
    lvl_n_d = lvl_n_q;
    cnt_d   = cnt_q;
    press_d = 1'b0;
    if (sync2_q == lvl_n_q) begin
      cnt_d = {CNT_W{1'b0}};
    end else if (cnt_q == CNT_LAST) begin
      lvl_n_d = sync2_q;
      cnt_d   = {CNT_W{1'b0}};
      // lvl_n_q high means we are leaving the released level: that is a press
      press_d = lvl_n_q;
    end else begin
      cnt_d = cnt_q + CNT_ONE;
    end
  end

  // Debounce state registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lvl_n_q <= 1'b1;
      cnt_q   <= {CNT_W{1'b0}};
      press_q <= 1'b0;
    end else begin
      lvl_n_q <= lvl_n_d;
      cnt_q   <= cnt_d;
      press_q <= press_d;
    end
  end

  assign level_o = ~lvl_n_q;
  assign press_o = press_q;

endmodule

// File: rtl/pbs_move_input.sv
// Player move entry: debounced confirm key plus synchronised move switches,
// captured on a clean press and offered to the control FSM via valid/ack.
module pbs_move_input
  import pbs_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 20
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              key_n,
  input  logic [MOVE_W-1:0] sw_move,
  input  logic              enable,
  input  logic              move_ack,
  output logic              move_valid,
  output logic [MOVE_W-1:0] move_out,
  output logic              key_held
);

  logic [MOVE_W-1:0] sw_sync1_q;
  logic [MOVE_W-1:0] sw_sync2_q;
  pbs_state_e        state_q;
  logic              move_valid_q;
  logic [MOVE_W-1:0] move_out_q;
  logic              level_s;
  logic              press_s;

  pbs_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .CNT_W           (CNT_W)
  ) u_debounce (
    .clk     (clk),
    .rst     (rst),
    .key_n_i (key_n),
    .level_o (level_s),
    .press_o (press_s)
  );

  // Synchronise the move switches; only the second-stage copy is captured
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sw_sync1_q <= {MOVE_W{1'b0}};
      sw_sync2_q <= {MOVE_W{1'b0}};
    end else begin
      sw_sync1_q <= sw_move;
      sw_sync2_q <= sw_sync1_q;
    end
  end

  // Offer FSM: one move per press, frozen while offered, re-armed only on release
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      move_valid_q <= 1'b0;
      move_out_q   <= {MOVE_W{1'b0}};
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (press_s) begin
            if (enable) begin
              move_out_q   <= sw_sync2_q;
              move_valid_q <= 1'b1;
              state_q      <= ST_OFFER;
            end else begin
              state_q <= ST_WAIT_REL;
            end
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_OFFER: begin
          // ack and abort retire the offer identically; ack simply has priority
          if (move_ack || !enable) begin
            move_valid_q <= 1'b0;
            state_q      <= level_s ? ST_WAIT_REL : ST_IDLE;
          end else begin
            state_q <= ST_OFFER;
          end
        end
        ST_WAIT_REL: begin
          if (!level_s) begin
            state_q <= ST_IDLE;
          end else begin
            state_q <= ST_WAIT_REL;
          end
        end
        default: begin
          state_q      <= ST_IDLE;
          move_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign move_valid = move_valid_q;
  assign move_out   = move_out_q;
  assign key_held   = level_s;

endmodule

// File: tb/tb_pbs_move_input.sv
// Bench for pbs_move_input with DEBOUNCE_CYCLES=4: directed scenarios plus a
// randomized phase, checked against a cycle-level reference model and a
// scoreboard of expected captured moves.
module tb_pbs_move_input;

  localparam int DC = 4;

  logic       clk;
  logic       rst;
  logic       key_n;
  logic [1:0] sw_move;
  logic       enable;
  logic       move_ack;
  logic       move_valid;
  logic [1:0] move_out;
  logic       key_held;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int rises    = 0;

  // reference model state
  logic       kh [0:5];   // kh[i] = key_n sampled i edges ago
  logic [1:0] sh [0:2];   // sh[i] = sw_move sampled i edges ago
  logic       m_held, m_press, m_valid, m_offer, m_waitrel;
  logic [1:0] m_out;
  logic [1:0] expq [$];
  logic       prev_valid;

  pbs_move_input #(.DEBOUNCE_CYCLES(DC), .CNT_W(3)) dut (
    .clk        (clk),
    .rst        (rst),
    .key_n      (key_n),
    .sw_move    (sw_move),
    .enable     (enable),
    .move_ack   (move_ack),
    .move_valid (move_valid),
    .move_out   (move_out),
    .key_held   (key_held)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < 6; i++) kh[i] = 1'b1;
    for (int i = 0; i < 3; i++) sh[i] = 2'b00;
    m_held = 1'b0; m_press = 1'b0; m_valid = 1'b0;
    m_offer = 1'b0; m_waitrel = 1'b0; m_out = 2'b00;
    expq.delete();
  endfunction

  // Reference model: a level change is accepted once the synced key (two
  // samples late) has disagreed with the accepted level for DC samples in a row
  always @(posedge clk) begin
    logic press_now, held_now, all_diff;
    cyc++;
    if (rst) begin
      model_reset();
    end else begin
      for (int i = 5; i > 0; i--) kh[i] = kh[i-1];
      kh[0] = key_n;
      for (int i = 2; i > 0; i--) sh[i] = sh[i-1];
      sh[0] = sw_move;
      press_now = m_press;
      held_now  = m_held;
      if (m_offer) begin
        if (move_ack || !enable) begin
          m_valid = 1'b0; m_offer = 1'b0; m_waitrel = held_now;
        end
      end else if (m_waitrel) begin
        if (!held_now) m_waitrel = 1'b0;
      end else if (press_now) begin
        if (enable) begin
          m_offer = 1'b1; m_valid = 1'b1; m_out = sh[2];
          expq.push_back(sh[2]);
        end else begin
          m_waitrel = 1'b1;
        end
      end
      all_diff = 1'b1;
      for (int i = 2; i < 2 + DC; i++) if (kh[i] != m_held) all_diff = 1'b0;
      if (all_diff) begin
        m_held  = !m_held;
        m_press = m_held;
      end else begin
        m_press = 1'b0;
      end
    end
  end

  // Monitor: per-cycle output comparison plus scoreboard pop on each new offer
  always @(negedge clk) begin
    if (!rst) begin
      check("valid", int'(move_valid), int'(m_valid));
      check("move_out", int'(move_out), int'(m_out));
      check("key_held", int'(key_held), int'(m_held));
      if (move_valid && !prev_valid) begin
        rises++;
        if (expq.size() == 0) begin
          check("sb_unexpected_offer", 1, 0);
        end else begin
          check("sb_move", int'(move_out), int'(expq.pop_front()));
        end
      end
    end
    prev_valid = move_valid;
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // returns edges from the call until move_valid is seen, -1 on timeout
  task automatic wait_valid(input int budget, output int lat);
    int c0;
    c0  = cyc;
    lat = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (move_valid) begin
        lat = cyc - c0;
        break;
      end
    end
  endtask

  task automatic do_ack();
    move_ack = 1'b1;
    step(1);
    move_ack = 1'b0;
    check("ack_clears_valid", int'(move_valid), 0);
  endtask

  task automatic release_key();
    key_n = 1'b1;
    step(10);
  endtask

  initial begin
    int lat, r0, hold_left;
    prev_valid = 1'b0;
    model_reset();
    rst = 1'b1; key_n = 1'b1; sw_move = 2'b00; enable = 1'b0; move_ack = 1'b0;
    step(3);
    check("rst_valid", int'(move_valid), 0);
    check("rst_out", int'(move_out), 0);
    check("rst_held", int'(key_held), 0);
    rst = 1'b0;
    step(2);

    // clean press, latency 2 + DC + 1
    sw_move = 2'b10; enable = 1'b1;
    step(3);
    key_n = 1'b0;
    wait_valid(20, lat);
    check("t2_latency", lat, 2 + DC + 1);
    check("t2_move", int'(move_out), 2);
    do_ack();
    release_key();

    // bounce: toggle every 2 cycles for 20 cycles, then hold pressed
    r0 = rises;
    for (int i = 0; i < 10; i++) begin
      key_n = i[0];
      step(2);
    end
    key_n = 1'b0;
    wait_valid(20, lat);
    check("t3_latency", lat, 2 + DC + 1);
    step(2);
    check("t3_single_pulse", rises - r0, 1);
    do_ack();
    release_key();

    // hold: no second move while held, new press after release works
    key_n = 1'b0;
    wait_valid(20, lat);
    check("t4_first", lat, 2 + DC + 1);
    do_ack();
    r0 = rises;
    step(50);
    check("t4_no_repeat", rises - r0, 0);
    release_key();
    key_n = 1'b0;
    wait_valid(20, lat);
    check("t4_second", lat, 2 + DC + 1);
    do_ack();
    release_key();

    // gating: press while disabled, then abort during offer
    enable = 1'b0;
    r0 = rises;
    key_n = 1'b0;
    step(15);
    check("t5_gated", rises - r0, 0);
    release_key();
    enable = 1'b1;
    key_n = 1'b0;
    wait_valid(20, lat);
    check("t5_offer", lat, 2 + DC + 1);
    enable = 1'b0;
    step(1);
    check("t5_abort", int'(move_valid), 0);
    enable = 1'b1;
    r0 = rises;
    step(15);
    check("t5_no_recapture", rises - r0, 0);
    release_key();
    key_n = 1'b0;
    wait_valid(20, lat);
    check("t5_new_press", lat, 2 + DC + 1);
    do_ack();
    release_key();

    // freeze: switch changes ignored while offered; ack with enable low
    sw_move = 2'b01;
    step(3);
    key_n = 1'b0;
    wait_valid(20, lat);
    check("t6_offer", lat, 2 + DC + 1);
    check("t6_move", int'(move_out), 1);
    sw_move = 2'b11;
    step(6);
    check("t6_frozen", int'(move_out), 1);
    check("t6_still_valid", int'(move_valid), 1);
    move_ack = 1'b1; enable = 1'b0;
    step(1);
    move_ack = 1'b0; enable = 1'b1;
    check("t6_ack_wins", int'(move_valid), 0);
    check("t6_out_kept", int'(move_out), 1);
    r0 = rises;
    step(8);
    check("t6_wait_release", rises - r0, 0);
    release_key();

    // asynchronous reset in the middle of an offer
    key_n = 1'b0;
    wait_valid(20, lat);
    check("t1_offer", lat, 2 + DC + 1);
    #2;
    rst = 1'b1;
    key_n = 1'b1;
    model_reset();
    #1;
    check("t1_async_valid", int'(move_valid), 0);
    check("t1_async_out", int'(move_out), 0);
    check("t1_async_held", int'(key_held), 0);
    step(2);
    rst = 1'b0;
    step(5);

    // randomized phase
    hold_left = 0;
    for (int i = 0; i < 2000; i++) begin
      if (hold_left == 0) begin
        key_n     = 1'($urandom_range(0, 1));
        hold_left = $urandom_range(1, 10);
      end
      hold_left--;
      if ($urandom_range(0, 3) == 0) sw_move = 2'($urandom);
      enable   = ($urandom_range(0, 7) != 0);
      move_ack = (m_valid && ($urandom_range(0, 1) == 1)) || ($urandom_range(0, 15) == 0);
      step(1);
    end
    move_ack = 1'b0;
    enable   = 1'b1;
    key_n    = 1'b1;
    step(12);
    check("sb_drained", expq.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Guard against a hung run
  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
